stream_demux_1_by_2: RTL and testbench
======================================

Name: stream_demux_1_by_2

Overview:
- Inverse of the 32-bit 2:1 select mux: one valid/ready input stream is steered to one of two output streams, A or B, by a per-word select bit.
- Words are buffered in-order in a small FIFO, so the producer (e.g. the writeback or MAC result path) is decoupled from the two consumers (e.g. register file port and matrix MAC operand buffer).
- Per-output transfer counters are provided for debug and performance monitoring.

Parameters:
DATA_W, 32, width of data word
DEPTH, 4, FIFO entries; power of 2, >= 2
CNT_W, 16, width of each per-output transfer counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  input word
in_sel  input  1  destination: 0 -> A, 1 -> B
a_valid  output  1  head word is destined for A
a_ready  input  1  consumer A accepts
a_data  output  DATA_W  head word data
b_valid  output  1  head word is destined for B
b_ready  input  1  consumer B accepts
b_data  output  DATA_W  head word data (same value as a_data)
occupancy  output  $clog2(DEPTH)+1  words currently stored
count_a  output  CNT_W  words delivered to A since reset
count_b  output  CNT_W  words delivered to B since reset

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: wr_ptr=0, rd_ptr=0, occupancy=0, count_a=0, count_b=0, a_valid=0, b_valid=0, in_ready=1. Storage array is not reset. Reset asserted mid-transfer discards all stored words immediately.
- Push: occurs when in_valid & in_ready. {in_sel, in_data} is written at wr_ptr, and wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- in_ready = (occupancy != DEPTH). It is a function of registered state only; there is no same-cycle pop bypass. When full, in_ready=0 even if a pop happens that cycle.
- Head outputs:
  - a_valid = (occupancy != 0) & ~head_sel
  - b_valid = (occupancy != 0) & head_sel
  - a_data = b_data = head data
  - At most one of a_valid or b_valid is high in any cycle.
- Pop: occurs when (a_valid & a_ready) | (b_valid & b_ready). rd_ptr increments modulo DEPTH. count_a or count_b increments by 1 and wraps at 2^CNT_W - 1 -> 0.
- Latency: a word pushed at edge N is visible on the outputs after edge N (cycle N+1) at the earliest, when the FIFO was empty. There is no combinational in->out path.
- Ordering: strict in-order delivery. A head word for B blocks later words for A, and vice versa. Head-of-line blocking is intended.
- Stability: while x_valid=1 and x_ready=0, x_data and x_valid hold unchanged. The ready of the non-selected output is ignored.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. This is legal at any occupancy in 1..DEPTH-1. At occupancy 0 only a push can occur; at DEPTH only a pop can occur.
- occupancy: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- in_valid while in_ready=0: no effect. The producer must hold its word.

Decomposition:
- Shared package: DATA_W default (32) and a typedef for the stored entry {sel, data}.
- Sub-module: sync_fifo (DEPTH x (DATA_W+1), with push/pop/full/empty/count).
- Top level: the steering logic and the two counters.

Test Plan:
- Reset, then push 0x0000_00A1 sel=0 with a_ready=1 -> a_valid=1 on the next cycle with a_data=0x0000_00A1. b_valid=0 throughout. count_a=1, count_b=0.
- Hold a_ready=b_ready=0 and push 4 words -> occupancy=4, in_ready=0. A 5th word is not accepted. Release ready -> 4 words emerge in push order.
- Push B:0x11, A:0x22, A:0x33 with a_ready=1, b_ready=0 -> nothing delivered (head-of-line block). Raise b_ready -> 0x11 on B, then 0x22 and 0x33 on A in consecutive cycles. count_a=2, count_b=1.
- Continuous push with alternating sel, both readies=1, 20 words -> one transfer per cycle, occupancy stays at 1, pointers wrap repeatedly, final count_a=10, count_b=10.
- Assert rst_n=0 asynchronously (between clock edges) with 3 words stored -> a_valid, b_valid and occupancy go to 0 immediately, before the next clock edge. After release, no stale data is delivered.
- Preload count_a to 0xFFFF (CNT_W=16) via 65535 A transfers, then 1 more -> count_a=0x0000.

Source files
------------

// File: rtl/stream_demux_1_by_2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_by_2_pkg
// Description : Shared defaults and the stored {sel, data} entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_1_by_2_pkg;

   localparam int c_DATA_W = 32;

   typedef struct packed {
      logic                sel;
      logic [c_DATA_W-1:0] data;
   } entry_t;

endpackage : stream_demux_1_by_2_pkg
`default_nettype wire

// File: rtl/stream_demux_1_by_2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; push/pop self-gated.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign full     = (r_count == c_FULL);
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];

   // Full blocks push even if a pop happens in the same cycle.
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer width matches log2(DEPTH), so increments wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/stream_demux_1_by_2.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_by_2
// Description : Buffered 1:2 stream demux steered by a per-word select bit.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_by_2
   import stream_demux_1_by_2_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_sel,
   output logic                     a_valid,
   input  logic                     a_ready,
   output logic [DATA_W-1:0]        a_data,
   output logic                     b_valid,
   input  logic                     b_ready,
   output logic [DATA_W-1:0]        b_data,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         count_a,
   output logic [CNT_W-1:0]         count_b
);

   logic [DATA_W:0] w_head;
   logic            w_full;
   logic            w_empty;
   logic            w_head_sel;
   logic            w_pop;
   logic [CNT_W-1:0] r_count_a;
   logic [CNT_W-1:0] r_count_b;

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid),
      .push_data ({in_sel, in_data}),
      .pop       (w_pop),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (occupancy)
   );

   assign in_ready   = ~w_full;
   assign w_head_sel = w_head[DATA_W];
   assign a_valid    = ~w_empty & ~w_head_sel;
   assign b_valid    = ~w_empty &  w_head_sel;
   assign a_data     = w_head[DATA_W-1:0];
   assign b_data     = w_head[DATA_W-1:0];

   // Only the ready of the output owning the head word can retire it.
   assign w_pop = (a_valid & a_ready) | (b_valid & b_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count_a <= '0;
         r_count_b <= '0;
      end else begin
         if (a_valid & a_ready) r_count_a <= r_count_a + CNT_W'(1);
         if (b_valid & b_ready) r_count_b <= r_count_b + CNT_W'(1);
      end
   end

   assign count_a = r_count_a;
   assign count_b = r_count_b;

endmodule : stream_demux_1_by_2
`default_nettype wire

// File: tb/tb_stream_demux_1_by_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1_by_2
// Description : Directed self-checking bench for stream_demux_1_by_2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_by_2;
   import stream_demux_1_by_2_pkg::*;

   localparam int c_DW    = 32;
   localparam int c_DEPTH = 4;
   localparam int c_CW    = 16;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [c_DW-1:0]   in_data;
   logic              in_sel;
   logic              a_valid;
   logic              a_ready;
   logic [c_DW-1:0]   a_data;
   logic              b_valid;
   logic              b_ready;
   logic [c_DW-1:0]   b_data;
   logic [2:0]        occupancy;
   logic [c_CW-1:0]   count_a;
   logic [c_CW-1:0]   count_b;

   int n_checks = 0;
   int n_fails  = 0;

   stream_demux_1_by_2 #(
      .DATA_W (c_DW),
      .DEPTH  (c_DEPTH),
      .CNT_W  (c_CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_data    (b_data),
      .occupancy (occupancy),
      .count_a   (count_a),
      .count_b   (count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Inputs change and outputs are checked on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_word(input logic sel, input logic [c_DW-1:0] data);
      entry_t e;
      e.sel  = sel;
      e.data = data;
      in_valid = 1'b1;
      in_sel   = e.sel;
      in_data  = e.data;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_sel   = 1'b0;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_a_valid",  a_valid, 0);
      check("rst_b_valid",  b_valid, 0);
      check("rst_occ",      occupancy, 0);
      check("rst_count_a",  count_a, 0);
      check("rst_count_b",  count_b, 0);

      // Single A word
      a_ready = 1'b1;
      push_word(1'b0, 32'h0000_00A1);
      check("t1_a_valid", a_valid, 1);
      check("t1_a_data",  a_data, 32'h0000_00A1);
      check("t1_b_valid", b_valid, 0);
      check("t1_occ",     occupancy, 1);
      step();
      check("t1_count_a", count_a, 1);
      check("t1_count_b", count_b, 0);
      check("t1_occ_end", occupancy, 0);
      check("t1_b_valid_end", b_valid, 0);

      // Fill to full, reject a fifth word, then drain in order
      a_ready = 1'b0;
      b_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(1'b0, 32'h100 + i);
      check("t2_occ_full", occupancy, 4);
      check("t2_in_ready", in_ready, 0);
      push_word(1'b0, 32'h1FF);
      check("t2_occ_after5", occupancy, 4);
      check("t2_head", a_data, 32'h100);
      a_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t2_drain_valid", a_valid, 1);
         check("t2_drain_data", a_data, 32'h100 + i);
         step();
      end
      check("t2_occ_empty", occupancy, 0);
      check("t2_count_a", count_a, 5);

      // Head-of-line blocking
      a_ready = 1'b1;
      b_ready = 1'b0;
      push_word(1'b1, 32'h11);
      push_word(1'b0, 32'h22);
      push_word(1'b0, 32'h33);
      step();
      check("t3_occ_blocked", occupancy, 3);
      check("t3_a_valid_blk", a_valid, 0);
      check("t3_b_valid_blk", b_valid, 1);
      check("t3_b_data_blk", b_data, 32'h11);
      check("t3_count_a_blk", count_a, 5);
      b_ready = 1'b1;
      step();
      check("t3_a_valid_1", a_valid, 1);
      check("t3_a_data_1", a_data, 32'h22);
      check("t3_count_b", count_b, 1);
      step();
      check("t3_a_data_2", a_data, 32'h33);
      step();
      check("t3_occ_end", occupancy, 0);
      check("t3_count_a", count_a, 7);
      check("t3_count_b_end", count_b, 1);

      // Continuous alternating stream, one transfer per cycle
      a_ready = 1'b1;
      b_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_sel   = i[0];
         in_data  = 32'h400 + i;
         step();
         check("t4_occ", occupancy, 1);
         check("t4_in_ready", in_ready, 1);
         if (i[0]) begin
            check("t4_b_valid", b_valid, 1);
            check("t4_b_data", b_data, 32'h400 + i);
         end else begin
            check("t4_a_valid", a_valid, 1);
            check("t4_a_data", a_data, 32'h400 + i);
         end
      end
      in_valid = 1'b0;
      step();
      check("t4_occ_end", occupancy, 0);
      check("t4_count_a", count_a, 17);
      check("t4_count_b", count_b, 11);

      // Asynchronous reset with words stored
      a_ready = 1'b0;
      b_ready = 1'b0;
      push_word(1'b0, 32'h501);
      push_word(1'b1, 32'h502);
      push_word(1'b0, 32'h503);
      check("t5_occ_pre", occupancy, 3);
      check("t5_a_valid_pre", a_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_a_valid_rst", a_valid, 0);
      check("t5_b_valid_rst", b_valid, 0);
      check("t5_occ_rst", occupancy, 0);
      check("t5_count_a_rst", count_a, 0);
      check("t5_in_ready_rst", in_ready, 1);
      @(negedge clk);
      rst_n   = 1'b1;
      a_ready = 1'b1;
      b_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_no_stale_a", a_valid, 0);
         check("t5_no_stale_b", b_valid, 0);
      end
      check("t5_count_a_post", count_a, 0);
      check("t5_count_b_post", count_b, 0);

      // Counter wrap: 65535 A transfers then one more
      in_sel   = 1'b0;
      in_data  = 32'hC0DE;
      in_valid = 1'b1;
      for (int i = 0; i < 65535; i++) step();
      in_valid = 1'b0;
      step();
      check("t6_count_a_max", count_a, 16'hFFFF);
      check("t6_occ", occupancy, 0);
      push_word(1'b0, 32'hC0DF);
      step();
      check("t6_count_a_wrap", count_a, 16'h0000);
      check("t6_count_b", count_b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_stream_demux_1_by_2
`default_nettype wire
